// File: rtl/pcs_10g_link_seq.sv
// ---------------------------------------------------------------------------
// pcs_10g_link_seq
//
// Bring-up and recovery sequencer for a 10GBASE-R PCS and its GTH transceiver.
// It orders the GTH TX and RX resets, releases the PCS datapath reset, waits
// for block lock, supervises lock loss and hi_ber while the link is up, and
// re-runs the RX recovery path with a bounded number of retries before
// parking in FAULT. Pure control: there is no datapath.
//
// Ports
//   clk              in   644 MHz clock, single domain
//   rst_n            in   asynchronous active-low reset
//   enable           in   0 parks the sequencer in IDLE with all resets asserted
//   restart          in   1-cycle pulse, full re-sequence from GT_TX_RST
//   gth_tx_rst_done  in   GTH TX reset complete (synchronous to clk)
//   gth_rx_rst_done  in   GTH RX reset complete (synchronous to clk)
//   block_lock       in   PCS block sync lock
//   hi_ber           in   PCS high bit-error-rate flag
//   gth_tx_reset     out  GTH TX reset request, active-high
//   gth_rx_reset     out  GTH RX reset request, active-high
//   pcs_rst_n        out  PCS datapath reset, active-low
//   tx_force_idle    out  1 replaces MAC TX with XGMII idle
//   link_ready       out  1 only in LINK_UP
//   fault            out  1 only in FAULT
//   seq_state [3:0]  out  encoded sequencer state
//   retry_cnt [3:0]  out  RX retries since the last LINK_UP or restart
//   relink_cnt[15:0] out  LINK_UP -> recovery events (saturating)
//
// Build option
//   LINK_SEQ_STATS_EN  defined: relink_cnt is a live saturating counter.
//                      undefined: relink_cnt is tied to zero.
// ---------------------------------------------------------------------------
module pcs_10g_link_seq #(
   parameter int GT_RST_CYC  = 16,
   parameter int PCS_RST_CYC = 8,
   parameter int LOCK_TMO    = 65536,
   parameter int LOSS_FILT   = 1024,
   parameter int MAX_RETRY   = 7
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic        restart,
   input  logic        gth_tx_rst_done,
   input  logic        gth_rx_rst_done,
   input  logic        block_lock,
   input  logic        hi_ber,
   output logic        gth_tx_reset,
   output logic        gth_rx_reset,
   output logic        pcs_rst_n,
   output logic        tx_force_idle,
   output logic        link_ready,
   output logic        fault,
   output logic [3:0]  seq_state,
   output logic [3:0]  retry_cnt,
   output logic [15:0] relink_cnt
);

   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      GT_TX_RST = 4'd1,
      WAIT_TX   = 4'd2,
      GT_RX_RST = 4'd3,
      WAIT_RX   = 4'd4,
      PCS_RST   = 4'd5,
      WAIT_LOCK = 4'd6,
      LINK_UP   = 4'd7,
      FAULT     = 4'd8
   } state_t;

   // Control outputs, grouped so they can be decoded from a state in one place.
   typedef struct packed {
      logic tx_rst;
      logic rx_rst;
      logic pcs_rst_n;
      logic force_idle;
      logic ready;
      logic fault;
   } ctl_t;

   localparam ctl_t CTL_RST = '{tx_rst: 1'b1, rx_rst: 1'b1, pcs_rst_n: 1'b0,
                                force_idle: 1'b1, ready: 1'b0, fault: 1'b0};

   // One shared timer serves the hold counts, the lock/RX timeout and the
   // loss filter; it is sized for the largest of them.
   localparam int MAX_AB  = (GT_RST_CYC > PCS_RST_CYC) ? GT_RST_CYC : PCS_RST_CYC;
   localparam int MAX_CD  = (LOCK_TMO > LOSS_FILT) ? LOCK_TMO : LOSS_FILT;
   localparam int TMR_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

   localparam logic [TMR_W-1:0] GT_RST_LAST  = TMR_W'(GT_RST_CYC - 1);
   localparam logic [TMR_W-1:0] PCS_RST_LAST = TMR_W'(PCS_RST_CYC - 1);
   localparam logic [TMR_W-1:0] LOCK_LAST    = TMR_W'(LOCK_TMO - 1);
   localparam logic [TMR_W-1:0] LOSS_LAST    = TMR_W'(LOSS_FILT - 1);
   localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRY);

   state_t           state;
   state_t           state_nxt;
   logic [TMR_W-1:0] tmr;
   logic [TMR_W-1:0] tmr_nxt;
   logic [3:0]       retry_nxt;
   logic             enter;
   logic             do_retry;
   ctl_t             ctl_nxt;
`ifdef LINK_SEQ_STATS_EN
   logic             relink_inc;
`endif

   // Output levels for each state. Anything not listed keeps the IDLE levels
   // (all resets asserted, TX forced idle).
   function automatic ctl_t decode(input state_t s);
      ctl_t c;
      c = CTL_RST;
      case (s)
         WAIT_TX:   c.tx_rst = 1'b0;
         GT_RX_RST: c.tx_rst = 1'b0;
         WAIT_RX, PCS_RST: begin
            c.tx_rst = 1'b0;
            c.rx_rst = 1'b0;
         end
         WAIT_LOCK: begin
            c.tx_rst    = 1'b0;
            c.rx_rst    = 1'b0;
            c.pcs_rst_n = 1'b1;
         end
         LINK_UP: begin
            c.tx_rst     = 1'b0;
            c.rx_rst     = 1'b0;
            c.pcs_rst_n  = 1'b1;
            c.force_idle = 1'b0;
            c.ready      = 1'b1;
         end
         FAULT:   c.fault = 1'b1;
         default: ;
      endcase
      return c;
   endfunction

   // Next-state logic. Priority: enable low, then restart, then the normal
   // per-state transitions.
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path through
      // the case statement can leave one unassigned and infer a latch.
      state_nxt = state;
      tmr_nxt   = tmr;
      retry_nxt = retry_cnt;
      enter     = 1'b0;
      do_retry  = 1'b0;
`ifdef LINK_SEQ_STATS_EN
      relink_inc = 1'b0;
`endif
      if (!enable) begin
         // Retry and relink counts hold while parked.
         if (state != IDLE) begin
            state_nxt = IDLE;
            enter     = 1'b1;
         end
      end else if (restart) begin
         state_nxt = GT_TX_RST;
         enter     = 1'b1;
         retry_nxt = '0;
      end else begin
         case (state)
            IDLE: begin
               state_nxt = GT_TX_RST;
               enter     = 1'b1;
            end
            GT_TX_RST: begin
               if (tmr == GT_RST_LAST) begin
                  state_nxt = WAIT_TX;
                  enter     = 1'b1;
               end else begin
                  tmr_nxt = tmr + 1'b1;
               end
            end
            WAIT_TX: begin
               // TX reset_done always arrives on the GTH, so no timeout here.
               if (gth_tx_rst_done) begin
                  state_nxt = GT_RX_RST;
                  enter     = 1'b1;
               end
            end
            GT_RX_RST: begin
               if (tmr == GT_RST_LAST) begin
                  state_nxt = WAIT_RX;
                  enter     = 1'b1;
               end else begin
                  tmr_nxt = tmr + 1'b1;
               end
            end
            WAIT_RX: begin
               if (gth_rx_rst_done) begin
                  state_nxt = PCS_RST;
                  enter     = 1'b1;
               end else if (tmr == LOCK_LAST) begin
                  do_retry = 1'b1;
               end else begin
                  tmr_nxt = tmr + 1'b1;
               end
            end
            PCS_RST: begin
               if (tmr == PCS_RST_LAST) begin
                  state_nxt = WAIT_LOCK;
                  enter     = 1'b1;
               end else begin
                  tmr_nxt = tmr + 1'b1;
               end
            end
            WAIT_LOCK: begin
               if (block_lock && !hi_ber) begin
                  state_nxt = LINK_UP;
                  enter     = 1'b1;
                  retry_nxt = '0;
               end else if (tmr == LOCK_LAST) begin
                  do_retry = 1'b1;
               end else begin
                  tmr_nxt = tmr + 1'b1;
               end
            end
            LINK_UP: begin
               // Loss filter: only an unbroken run of bad cycles drops the link;
               // any good cycle restarts the count.
               if (!block_lock || hi_ber) begin
                  if (tmr == LOSS_LAST) begin
                     state_nxt = GT_RX_RST;
                     enter     = 1'b1;
                     retry_nxt = '0;
`ifdef LINK_SEQ_STATS_EN
                     relink_inc = 1'b1;
`endif
                  end else begin
                     tmr_nxt = tmr + 1'b1;
                  end
               end else begin
                  tmr_nxt = '0;
               end
            end
            FAULT: ;  // leaves only via restart or enable low
            default: begin
               state_nxt = IDLE;
               enter     = 1'b1;
            end
         endcase

         // Recovery re-runs only the RX side; the TX side stays up.
         if (do_retry) begin
            enter = 1'b1;
            if (retry_cnt == RETRY_MAX) begin
               state_nxt = FAULT;
            end else begin
               state_nxt = GT_RX_RST;
               retry_nxt = retry_cnt + 1'b1;
            end
         end
      end

      if (enter) tmr_nxt = '0;
   end

   // Outputs are registered from the next state so they change on the same
   // edge as seq_state.
   assign ctl_nxt   = decode(state_nxt);
   assign seq_state = state;

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (!rst_n) begin
         state     <= IDLE;
         tmr       <= '0;
         retry_cnt <= '0;
         {gth_tx_reset, gth_rx_reset, pcs_rst_n,
          tx_force_idle, link_ready, fault} <= CTL_RST;
      end else begin
         state     <= state_nxt;
         tmr       <= tmr_nxt;
         retry_cnt <= retry_nxt;
         {gth_tx_reset, gth_rx_reset, pcs_rst_n,
          tx_force_idle, link_ready, fault} <= ctl_nxt;
      end
   end

`ifdef LINK_SEQ_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         relink_cnt <= '0;
      end else if (relink_inc && (relink_cnt != 16'hFFFF)) begin
         relink_cnt <= relink_cnt + 1'b1;
      end
   end
`else
   assign relink_cnt = 16'h0000;
`endif

endmodule
